vga_tty_writer: RTL and testbench

//  Byte-stream terminal front end upstream of vga_top's DMA port. Takes characters from the
//  SPI bridge over a valid/ready handshake and interprets the control codes CR, LF, BS, FF and ESC.

---
 rtl/vga_tty_writer.sv | 210 +++++++++++++++++++++
 tb/tb_vga_tty_writer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_tty_writer.sv
// rtl/vga_tty_writer.sv - byte-stream 80x25 text terminal writer feeding video/attribute RAM
// Optional VGA_TTY_COLOR_EN: ESC <attr> sets the attribute used for printable writes.
module vga_tty_writer #(
  parameter int         COLS         = 80,
  parameter int         ROWS         = 25,
  parameter int         ADR_W        = 11,
  parameter logic [7:0] BLANK_CHAR   = 8'h20,
  parameter logic [7:0] DEFAULT_ATTR = 8'h07
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [7:0]       i_data,
  input  logic             i_valid,
  output logic             o_ready,
  output logic [ADR_W-1:0] o_vram_adr,
  output logic [7:0]       o_vram_data,
  output logic [7:0]       o_cram_data,
  output logic             o_vram_we,
  output logic [ADR_W-1:0] o_cursor_adr,
  output logic             o_cursor_on,
  output logic             o_busy
);

  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [COL_W-1:0] LAST_COL     = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] LAST_ROW     = ROW_W'(ROWS - 1);
  localparam logic [ADR_W-1:0] LAST_CELL    = ADR_W'(COLS * ROWS - 1);
  localparam logic [ADR_W-1:0] LAST_ROW0    = ADR_W'(COLS - 1);
  localparam logic [ADR_W-1:0] ROW_STRIDE   = ADR_W'(COLS);

  localparam logic [7:0] CH_BS  = 8'h08;
  localparam logic [7:0] CH_LF  = 8'h0A;
  localparam logic [7:0] CH_FF  = 8'h0C;
  localparam logic [7:0] CH_CR  = 8'h0D;
  localparam logic [7:0] CH_ESC = 8'h1B;

  typedef enum logic [2:0] {
    S_RST,
    S_CLR_ALL,
    S_IDLE,
    S_WRITE,
    S_CTRL,
    S_CLR_ROW
`ifdef VGA_TTY_COLOR_EN
    , S_ESC_ATTR
`endif
  } state_t;

  state_t           state, state_next;
  logic [ADR_W-1:0] cur_adr;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic [7:0]       byte_q;
  logic [ADR_W-1:0] clr_adr;
  logic [7:0]       attr;

`ifdef VGA_TTY_COLOR_EN
  logic esc_pend;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      attr     <= DEFAULT_ATTR;
      esc_pend <= 1'b0;
    end else if (state == S_CTRL && byte_q == CH_ESC) begin
      esc_pend <= 1'b1;
    end else if (state == S_ESC_ATTR) begin
      attr     <= byte_q;
      esc_pend <= 1'b0;
    end
  end
`else
  assign attr = DEFAULT_ATTR;
`endif

  assign o_cursor_adr = cur_adr;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state <= S_RST;
    else          state <= state_next;
  end

  always_comb begin
    state_next  = state;
    o_ready     = 1'b0;
    o_vram_we   = 1'b0;
    o_vram_adr  = '0;
    o_vram_data = 8'h00;
    o_cram_data = DEFAULT_ATTR;
    o_busy      = 1'b0;
    o_cursor_on = 1'b1;
    case (state)
      S_RST: begin
        o_busy      = 1'b1;
        o_cursor_on = 1'b0;
        state_next  = S_CLR_ALL;
      end
      S_CLR_ALL: begin
        o_busy      = 1'b1;
        o_cursor_on = 1'b0;
        o_vram_we   = 1'b1;
        o_vram_adr  = clr_adr;
        o_vram_data = BLANK_CHAR;
        if (clr_adr == LAST_CELL) state_next = S_IDLE;
      end
      S_CLR_ROW: begin
        o_busy      = 1'b1;
        o_cursor_on = 1'b0;
        o_vram_we   = 1'b1;
        o_vram_adr  = clr_adr;
        o_vram_data = BLANK_CHAR;
        if (clr_adr == LAST_ROW0) state_next = S_IDLE;
      end
      S_IDLE: begin
        o_ready = 1'b1;
        if (i_valid) begin
          if (i_data >= 8'h20)      state_next = S_WRITE;
          else if (i_data == CH_FF) state_next = S_CLR_ALL;
          else                      state_next = S_CTRL;
`ifdef VGA_TTY_COLOR_EN
          if (esc_pend) state_next = S_ESC_ATTR;
`endif
        end
      end
      S_WRITE: begin
        o_vram_we   = 1'b1;
        o_vram_adr  = cur_adr;
        o_vram_data = byte_q;
        o_cram_data = attr;
        if (col == LAST_COL && row == LAST_ROW) state_next = S_CLR_ROW;
        else                                    state_next = S_IDLE;
      end
      S_CTRL: begin
        if (byte_q == CH_LF && row == LAST_ROW) state_next = S_CLR_ROW;
        else                                    state_next = S_IDLE;
      end
`ifdef VGA_TTY_COLOR_EN
      S_ESC_ATTR: state_next = S_IDLE;
`endif
      default: state_next = S_RST;
    endcase
  end

  // Cursor is tracked both linearly and as col/row so wraps never need a multiply.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      cur_adr <= '0;
      col     <= '0;
      row     <= '0;
      byte_q  <= 8'h00;
      clr_adr <= '0;
    end else begin
      case (state)
        S_RST: clr_adr <= '0;
        S_CLR_ALL: begin
          clr_adr <= clr_adr + 1'b1;
          cur_adr <= '0;
          col     <= '0;
          row     <= '0;
        end
        S_CLR_ROW: clr_adr <= clr_adr + 1'b1;
        S_IDLE: begin
          clr_adr <= '0;
          if (i_valid) byte_q <= i_data;
        end
        S_WRITE: begin
          if (col == LAST_COL) begin
            col <= '0;
            if (row == LAST_ROW) begin
              row     <= '0;
              cur_adr <= '0;
            end else begin
              row     <= row + 1'b1;
              cur_adr <= cur_adr + 1'b1;
            end
          end else begin
            col     <= col + 1'b1;
            cur_adr <= cur_adr + 1'b1;
          end
        end
        S_CTRL: begin
          case (byte_q)
            CH_CR: begin
              cur_adr <= cur_adr - ADR_W'(col);
              col     <= '0;
            end
            CH_LF: begin
              if (row == LAST_ROW) begin
                row     <= '0;
                cur_adr <= ADR_W'(col);
              end else begin
                row     <= row + 1'b1;
                cur_adr <= cur_adr + ROW_STRIDE;
              end
            end
            CH_BS: begin
              if (col != '0) begin
                col     <= col - 1'b1;
                cur_adr <= cur_adr - 1'b1;
              end
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_tty_writer.sv
// tb/tb_vga_tty_writer.sv - directed self-checking bench for vga_tty_writer
module tb_vga_tty_writer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  data;
  logic        valid;
  logic        ready;
  logic [10:0] vram_adr;
  logic [7:0]  vram_data;
  logic [7:0]  cram_data;
  logic        vram_we;
  logic [10:0] cursor_adr;
  logic        cursor_on;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;
  int wr_adr[$];
  int wr_dat[$];
  int wr_att[$];

  always #20 clk = ~clk;

  vga_tty_writer dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_data       (data),
    .i_valid      (valid),
    .o_ready      (ready),
    .o_vram_adr   (vram_adr),
    .o_vram_data  (vram_data),
    .o_cram_data  (cram_data),
    .o_vram_we    (vram_we),
    .o_cursor_adr (cursor_adr),
    .o_cursor_on  (cursor_on),
    .o_busy       (busy)
  );

  always @(negedge clk) begin
    if (vram_we === 1'b1) begin
      wr_adr.push_back(int'(vram_adr));
      wr_dat.push_back(int'(vram_data));
      wr_att.push_back(int'(cram_data));
    end
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic clear_log();
    wr_adr.delete();
    wr_dat.delete();
    wr_att.delete();
  endtask

  // Entries from first on must be blank writes at ascending addresses from adr0.
  function automatic int count_bad_blanks(input int first, input int num, input int adr0);
    int bad = 0;
    for (int i = 0; i < num; i++) begin
      if (first + i >= wr_adr.size()) bad++;
      else if (wr_adr[first+i] != adr0 + i || wr_dat[first+i] != 8'h20 || wr_att[first+i] != 8'h07) bad++;
    end
    return bad;
  endfunction

  // Called at a negedge with ready high; returns at a negedge with ready high again.
  task automatic send(input logic [7:0] b, output int cyc);
    data  = b;
    valid = 1'b1;
    @(posedge clk);
    #1 valid = 1'b0;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (ready !== 1'b1 && cyc < 5000);
    if (ready !== 1'b1) check_eq("send_timeout", int'(ready), 1);
  endtask

  task automatic send_n(input logic [7:0] b, input int n);
    int c;
    for (int i = 0; i < n; i++) send(b, c);
  endtask

  task automatic reset_and_clear(input int hold);
    int cnt;
    rst_n = 1'b0;
    valid = 1'b0;
    repeat (hold) @(posedge clk);
    @(negedge clk);
    check_eq("rst_ready", int'(ready), 0);
    check_eq("rst_we", int'(vram_we), 0);
    check_eq("rst_adr", int'(vram_adr), 0);
    check_eq("rst_data", int'(vram_data), 0);
    check_eq("rst_cram", int'(cram_data), 8'h07);
    check_eq("rst_cursor", int'(cursor_adr), 0);
    check_eq("rst_cursor_on", int'(cursor_on), 0);
    check_eq("rst_busy", int'(busy), 1);
    clear_log();
    rst_n = 1'b1;
    cnt = 0;
    do begin
      @(negedge clk);
      if (busy === 1'b1) cnt++;
    end while (busy === 1'b1 && cnt < 3000);
    check_eq("init_busy_cycles", cnt, 2000);
    check_eq("init_write_count", wr_adr.size(), 2000);
    check_eq("init_bad_blanks", count_bad_blanks(0, 2000, 0), 0);
    check_eq("init_ready", int'(ready), 1);
    check_eq("init_cursor_on", int'(cursor_on), 1);
    check_eq("init_cursor", int'(cursor_adr), 0);
  endtask

  initial begin
    int c;
    int cnt;
    rst_n = 1'b0;
    valid = 1'b0;
    data  = 8'h00;
    reset_and_clear(3);

    clear_log();
    send(8'h08, c);
    check_eq("bs_at_0_cursor", int'(cursor_adr), 0);
    check_eq("bs_at_0_writes", wr_adr.size(), 0);
    check_eq("bs_ready_gap", c, 2);

    send(8'h41, c);
    check_eq("a_count", wr_adr.size(), 1);
    check_eq("a_adr", wr_adr.size() > 0 ? wr_adr[0] : -1, 0);
    check_eq("a_data", wr_dat.size() > 0 ? wr_dat[0] : -1, 8'h41);
    check_eq("a_cram", wr_att.size() > 0 ? wr_att[0] : -1, 8'h07);
    check_eq("a_cursor", int'(cursor_adr), 1);
    check_eq("a_ready_gap", c, 2);

    clear_log();
    send(8'h0D, c);
    check_eq("cr_cursor", int'(cursor_adr), 0);
    send(8'h0A, c);
    check_eq("lf_cursor", int'(cursor_adr), 80);
    check_eq("crlf_writes", wr_adr.size(), 0);

    send(8'h62, c);
    check_eq("b81_adr", wr_adr.size() > 0 ? wr_adr[0] : -1, 80);
    check_eq("b81_cursor", int'(cursor_adr), 81);
    send(8'h08, c);
    check_eq("bs_81_cursor", int'(cursor_adr), 80);
    check_eq("bs_81_writes", wr_adr.size(), 1);

    send_n(8'h0A, 23);
    check_eq("lf23_cursor", int'(cursor_adr), 1920);
    send_n(8'h78, 79);
    check_eq("cursor_1999", int'(cursor_adr), 1999);

    clear_log();
    send(8'h5A, c);
    check_eq("z_ready_low", c - 1, 81);
    check_eq("z_write_count", wr_adr.size(), 81);
    check_eq("z_adr", wr_adr.size() > 0 ? wr_adr[0] : -1, 1999);
    check_eq("z_data", wr_dat.size() > 0 ? wr_dat[0] : -1, 8'h5A);
    check_eq("z_row_clear", count_bad_blanks(1, 80, 0), 0);
    check_eq("z_cursor", int'(cursor_adr), 0);

    send_n(8'h78, 79);
    check_eq("cursor_79", int'(cursor_adr), 79);
    clear_log();
    send(8'h42, c);
    check_eq("b79_adr", wr_adr.size() > 0 ? wr_adr[0] : -1, 79);
    check_eq("b79_data", wr_dat.size() > 0 ? wr_dat[0] : -1, 8'h42);
    check_eq("b79_cursor", int'(cursor_adr), 80);

    send_n(8'h0A, 5);
    send_n(8'h79, 20);
    check_eq("cursor_500", int'(cursor_adr), 500);

    // FF with i_valid held: the trailing 'Q' must wait out the whole clear.
    clear_log();
    data  = 8'h0C;
    valid = 1'b1;
    @(posedge clk);
    #1 data = 8'h51;
    cnt = 0;
    do begin
      @(negedge clk);
      if (ready !== 1'b1) cnt++;
    end while (ready !== 1'b1 && cnt < 3000);
    check_eq("ff_ready_low", cnt, 2000);
    check_eq("ff_cursor", int'(cursor_adr), 0);
    @(posedge clk);
    #1 valid = 1'b0;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (ready !== 1'b1 && c < 100);
    check_eq("ff_write_count", wr_adr.size(), 2001);
    check_eq("ff_clear", count_bad_blanks(0, 2000, 0), 0);
    check_eq("ff_q_data", wr_dat.size() > 2000 ? wr_dat[2000] : -1, 8'h51);
    check_eq("ff_q_adr", wr_adr.size() > 2000 ? wr_adr[2000] : -1, 0);
    check_eq("ff_q_cursor", int'(cursor_adr), 1);

    clear_log();
    send(8'h01, c);
    check_eq("ign_ready_gap", c, 2);
    check_eq("ign_cursor", int'(cursor_adr), 1);
    check_eq("ign_writes", wr_adr.size(), 0);

    send(8'h1B, c);
    send(8'h1E, c);
    send(8'h43, c);
    check_eq("esc_write_count", wr_adr.size(), 1);
    check_eq("esc_c_adr", wr_adr.size() > 0 ? wr_adr[0] : -1, 1);
    check_eq("esc_c_data", wr_dat.size() > 0 ? wr_dat[0] : -1, 8'h43);
`ifdef VGA_TTY_COLOR_EN
    check_eq("esc_c_cram", wr_att.size() > 0 ? wr_att[0] : -1, 8'h1E);
`else
    check_eq("esc_c_cram", wr_att.size() > 0 ? wr_att[0] : -1, 8'h07);
`endif
    check_eq("esc_cursor", int'(cursor_adr), 2);

    data  = 8'h0C;
    valid = 1'b1;
    @(posedge clk);
    #1 valid = 1'b0;
    repeat (300) @(negedge clk);
    check_eq("mid_clear_busy", int'(busy), 1);
    reset_and_clear(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #4000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
